// File: rtl/uart16450_lite.sv
// rtl/uart16450_lite.sv - 16450-subset UART responder: register file, baud tick, 8N1 TX/RX serialisers.
module uart16450_lite #(
    parameter logic [15:0] DIV_RESET = 16'd1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       we,
    input  logic       re,
    input  logic       ce,
    input  logic       rxd,
    output logic       txd,
    output logic       irq
);
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic [3:0]  ier;
    logic [7:0]  lcr, scr, dll, dlm, rbr, thr, iir, lsr;
    logic [4:0]  mcr;
    logic        we_q, re_q, wr_ev, rd_ev, dlab;
    logic        wr_thr, wr_dl, wr_ier, rd_rbr, rd_iir, rd_lsr;
    logic [15:0] divisor, bcnt;
    logic        reload_q, tick;
    logic        thr_full, thre, temt, thre_pend, transfer;
    logic        tx_busy, tx_serial;
    logic [9:0]  tx_sh;
    logic [3:0]  tx_tcnt, tx_bcnt;
    logic        rx_s1, rx_s2, rx_in, rx_prev, rx_fall, rx_sample, frame_done;
    logic [3:0]  rx_tcnt;
    logic [2:0]  rx_bcnt;
    logic [7:0]  rx_sh;
    logic        dr, oe, fe;
    rx_state_t   rx_state, rx_next;

    // A held bus access produces exactly one event, on its first cycle.
    assign wr_ev  = ce & we & ~we_q;
    assign rd_ev  = ce & re & ~re_q;
    assign dlab   = lcr[7];
    assign wr_thr = wr_ev & (addr == 3'd0) & ~dlab;
    assign wr_dl  = wr_ev & dlab & ((addr == 3'd0) | (addr == 3'd1));
    assign wr_ier = wr_ev & (addr == 3'd1) & ~dlab;
    assign rd_rbr = rd_ev & (addr == 3'd0) & ~dlab;
    assign rd_iir = rd_ev & (addr == 3'd2);
    assign rd_lsr = rd_ev & (addr == 3'd5);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q <= 1'b0; re_q <= 1'b0;
            ier <= 4'd0; lcr <= 8'd0; mcr <= 5'd0; scr <= 8'd0;
            dll <= DIV_RESET[7:0]; dlm <= DIV_RESET[15:8];
        end else begin
            we_q <= ce & we;
            re_q <= ce & re;
            if (wr_ev) begin
                case (addr)
                    3'd0: if (dlab) dll <= din;
                    3'd1: if (dlab) dlm <= din; else ier <= din[3:0];
                    3'd3: lcr <= din;
                    3'd4: mcr <= din[4:0];
                    3'd7: scr <= din;
                    default: ;
                endcase
            end
        end
    end

    // Divisor of zero parks the counter at zero, so no ticks are produced.
    assign divisor = {dlm, dll};
    assign tick    = (bcnt == 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt     <= DIV_RESET;
            reload_q <= 1'b0;
        end else begin
            reload_q <= wr_dl;
            if (reload_q || bcnt <= 16'd1) bcnt <= divisor;
            else                           bcnt <= bcnt - 16'd1;
        end
    end

    assign transfer  = ~tx_busy & thr_full;
    assign thre      = ~thr_full;
    assign temt      = thre & ~tx_busy;
    assign tx_serial = tx_busy ? tx_sh[0] : 1'b1;
    assign txd       = mcr[4] | tx_serial;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thr <= 8'd0; thr_full <= 1'b0; tx_busy <= 1'b0;
            tx_sh <= 10'h3ff; tx_tcnt <= 4'd0; tx_bcnt <= 4'd0;
        end else begin
            if (wr_thr) begin
                thr      <= din;
                thr_full <= 1'b1;
            end else if (transfer) begin
                thr_full <= 1'b0;
            end
            if (transfer) begin
                tx_sh   <= {1'b1, thr, 1'b0};
                tx_busy <= 1'b1;
                tx_tcnt <= 4'd0;
                tx_bcnt <= 4'd0;
            end else if (tx_busy && tick) begin
                tx_tcnt <= tx_tcnt + 4'd1;
                if (tx_tcnt == 4'd15) begin
                    if (tx_bcnt == 4'd9) begin
                        tx_busy <= 1'b0;
                    end else begin
                        tx_sh   <= {1'b1, tx_sh[9:1]};
                        tx_bcnt <= tx_bcnt + 4'd1;
                    end
                end
            end
        end
    end

    // Loopback feeds the serialiser straight in, skipping the synchroniser.
    assign rx_in     = mcr[4] ? tx_serial : rx_s2;
    assign rx_fall   = rx_prev & ~rx_in;
    assign rx_sample = tick & ((rx_state == RX_START) ? (rx_tcnt == 4'd7) : (rx_tcnt == 4'd15));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state <= RX_IDLE;
        else        rx_state <= rx_next;
    end

    always_comb begin
        rx_next    = rx_state;
        frame_done = 1'b0;
        case (rx_state)
            RX_IDLE:  if (rx_fall) rx_next = RX_START;
            RX_START: if (rx_sample) rx_next = rx_in ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_sample && rx_bcnt == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (rx_sample) begin
                          rx_next    = RX_IDLE;
                          frame_done = 1'b1;
                      end
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1; rx_s2 <= 1'b1; rx_prev <= 1'b1;
            rx_tcnt <= 4'd0; rx_bcnt <= 3'd0; rx_sh <= 8'd0;
        end else begin
            rx_s1   <= rxd;
            rx_s2   <= rx_s1;
            rx_prev <= rx_in;
            if (rx_state == RX_IDLE) begin
                rx_tcnt <= 4'd0;
                rx_bcnt <= 3'd0;
            end else if (tick) begin
                rx_tcnt <= rx_sample ? 4'd0 : rx_tcnt + 4'd1;
                if (rx_sample && rx_state == RX_DATA) begin
                    rx_sh   <= {rx_in, rx_sh[7:1]};
                    rx_bcnt <= rx_bcnt + 3'd1;
                end
            end
        end
    end

    // A completing frame takes precedence over a clearing read in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rbr <= 8'd0; dr <= 1'b0; oe <= 1'b0; fe <= 1'b0; thre_pend <= 1'b0;
        end else begin
            if (frame_done) begin
                rbr <= rx_sh;
                dr  <= 1'b1;
                oe  <= oe | dr;
                fe  <= fe | ~rx_in;
            end else begin
                if (rd_rbr) dr <= 1'b0;
                if (rd_lsr) begin
                    oe <= 1'b0;
                    fe <= 1'b0;
                end
            end
            if ((transfer & ~wr_thr) | (wr_ier & ~ier[1] & din[1] & thre))
                thre_pend <= 1'b1;
            else if (wr_thr | (rd_iir & (iir == 8'h02)))
                thre_pend <= 1'b0;
        end
    end

    assign lsr = {1'b0, temt, thre, 1'b0, fe, 1'b0, oe, dr};
    assign irq = ~iir[0];

    always_comb begin
        iir = 8'h01;
        if ((oe | fe) & ier[2])      iir = 8'h06;
        else if (dr & ier[0])        iir = 8'h04;
        else if (thre_pend & ier[1]) iir = 8'h02;
    end

    always_comb begin
        dout = 8'h00;
        case (addr)
            3'd0: dout = dlab ? dll : rbr;
            3'd1: dout = dlab ? dlm : {4'd0, ier};
            3'd2: dout = iir;
            3'd3: dout = lcr;
            3'd4: dout = {3'd0, mcr};
            3'd5: dout = lsr;
            3'd6: dout = 8'h00;
            3'd7: dout = scr;
            default: dout = 8'h00;
        endcase
    end
endmodule
